bus_master_ctrl: RTL and testbench
==================================

// Module: bus_master_ctrl
// PURPOSE
//  Bus initiator for the shared tristate data bus. Generates CS/WE/OE/CNT_EN/SYNC_CLR
//  and drives or samples data so the CPU datapath can read, write, increment or clear
//  bus-attached registers and counters. Accepts one command per req/done handshake and
//  sequences it as SETUP -> STROBE -> DONE. It sits between the control unit and the
//  register/counter slaves.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH  width of data bus, wdata, rdata
//  NUM_DEV     4            number of slaves; one CS line each
//  ADDR_WIDTH  2            width of addr; must satisfy 2**ADDR_WIDTH >= NUM_DEV
// PORTS
//  clk       in     1           clock, all state changes on posedge
//  reset     in     1           reset, synchronous, active-low
//  req       in     1           command request, sampled only in IDLE
//  op        in     2           00 READ, 01 WRITE, 10 INC, 11 CLR
//  addr      in     ADDR_WIDTH  target slave index
//  wdata     in     DATA_WIDTH  write data (WRITE only)
//  busy      out    1           high in SETUP/STROBE/DONE
//  done      out    1           one-cycle pulse in DONE
//  err       out    1           with done: addr >= NUM_DEV, no bus strobe issued
//  rdata     out    DATA_WIDTH  read result, updated on READ completion only
//  CS        out    NUM_DEV     one-hot chip selects
//  WE, OE    out    1           shared write/output enables
//  CNT_EN    out    1           shared count enable (qualified by CS at slave)
//  SYNC_CLR  out    1           shared synchronous clear (slaves ignore CS: broadcast)
//  data      inout  DATA_WIDTH  shared tristate bus
// BEHAVIOUR
//  - All bus outputs are registered; data is driven from a registered value and enable.
//  - Reset (reset==0 at posedge): state=IDLE. CS=0, WE=OE=CNT_EN=SYNC_CLR=0, data=Z,
//    busy=done=err=0, rdata=0. A reset mid-operation aborts the command, with no done.
//  - IDLE: if req==1, latch op/addr/wdata. Go to SETUP. Otherwise stay; all strobes 0, data=Z.
//  - SETUP (1 cycle): CS[addr]=1, others 0. WE=OE=CNT_EN=SYNC_CLR=0. For WRITE, drive
//    data=wdata; otherwise data=Z. For CLR, CS is all-zero. If addr>=NUM_DEV and op!=CLR,
//    CS is all-zero, err is set, and the FSM skips STROBE and goes to DONE.
//  - STROBE (1 cycle): CS held. READ: OE=1, data=Z, rdata<=data at the closing edge.
//    WRITE: WE=1, data=wdata, and the slave latches it at the closing edge. INC: CNT_EN=1.
//    CLR: SYNC_CLR=1. WE and OE are never both 1 (the slave flags that as illegal).
//  - DONE (1 cycle): all strobes 0, CS=0, data=Z (turnaround), done=1, err valid. Then IDLE.
//  - Latency: req in IDLE at edge N -> done high during cycle N+3. Throughput is one
//    command per 4 cycles. req in a non-IDLE state is ignored; it is not queued.
//  - Bus contention rule: the controller drives data only in SETUP/STROBE of a WRITE.
//    Any cycle with OE=1 has data released.
//  - rdata holds its value across non-READ commands and error commands.
//  - INC wraps per slave arithmetic (all-ones -> 0). The controller does no arithmetic.
// TESTING
//  1. Reset low 2 cycles mid-WRITE -> next cycle CS=0, WE=0, data=Z, busy=0, no done pulse.
//  2. WRITE addr=1 wdata=8'hA5 then READ addr=1 -> done at N+3 each, rdata=8'hA5, CS=4'b0010.
//  3. WRITE addr=2 8'hFF, INC addr=2, READ addr=2 -> rdata=8'h00 (wrap), WE/OE never both high.
//  4. Write 3,7 to slaves 0,3, CLR, READ both -> both read 0 and SYNC_CLR pulses for 1 cycle.
//  5. NUM_DEV=3, READ addr=3 -> done=1, err=1, CS stays 0 all cycles, rdata unchanged.
//  6. Hold req=1 continuously with alternating ops -> one command accepted every 4 cycles.
//     No bus cycle ever has the controller driving data while OE=1.

Source files
------------

// File: rtl/bus_master_ctrl_if.sv
//==============================================================================
// Module   : bus_master_ctrl_if
// Purpose  : Command handshake and bus-control signal bundle between the
//            control unit, the bus initiator and the register/counter slaves.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bus_master_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DEV    = 4,
  parameter int ADDR_WIDTH = 2
);
  // Command side
  logic                  req;
  logic [1:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  // Bus control side
  logic [NUM_DEV-1:0]    CS;
  logic                  WE;
  logic                  OE;
  logic                  CNT_EN;
  logic                  SYNC_CLR;

  modport master (
    input  req, op, addr, wdata,
    output busy, done, err, rdata,
    output CS, WE, OE, CNT_EN, SYNC_CLR
  );

  modport slave (
    output req, op, addr, wdata,
    input  busy, done, err, rdata,
    input  CS, WE, OE, CNT_EN, SYNC_CLR
  );
endinterface

`default_nettype wire

// File: rtl/bus_master_ctrl.sv
//==============================================================================
// Module   : bus_master_ctrl
// Purpose  : Bus initiator for the shared tristate data bus. Sequences one
//            READ/WRITE/INC/CLR command per req/done handshake through
//            SETUP -> STROBE -> DONE with fully registered bus outputs.
//            The data bus is a plain inout so all drivers resolve on one net.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DEV    = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_master_ctrl_if.master     bus,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic [ADDR_WIDTH:0] NUM_DEV_W = (ADDR_WIDTH+1)'(NUM_DEV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [NUM_DEV-1:0]    cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  cnt_en_q, cnt_en_d;
  logic                  sync_clr_q, sync_clr_d;
  logic                  data_oe_q, data_oe_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_DEV-1:0]    cs_dec;
  logic                  addr_ok;
  logic                  cmd_bad;

  // One chip-select line per slave, decoded from the incoming address
  for (genvar i = 0; i < NUM_DEV; i++) begin : g_cs_dec
    assign cs_dec[i] = (bus.addr == ADDR_WIDTH'(i));
  end

  // CLR is a broadcast, so an out-of-range address is only an error for the others
  assign addr_ok = ({1'b0, bus.addr} < NUM_DEV_W);
  assign cmd_bad = !addr_ok && (bus.op != OP_CLR);

  // Next-state and next-output computation; every output is the flop of its _d
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cs_d       = '0;
    we_d       = 1'b0;
    oe_d       = 1'b0;
    cnt_en_d   = 1'b0;
    sync_clr_d = 1'b0;
    data_oe_d  = 1'b0;
    data_out_d = data_out_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d    = S_SETUP;
          op_d       = bus.op;
          data_out_d = bus.wdata;
          busy_d     = 1'b1;
          err_d      = cmd_bad;
          cs_d       = (bus.op == OP_CLR || cmd_bad) ? '0 : cs_dec;
          // Drive write data a cycle early so it is stable before WE rises
          data_oe_d  = (bus.op == OP_WRITE) && !cmd_bad;
        end
      end
      S_SETUP: begin
        busy_d = 1'b1;
        if (err_q) begin
          // No bus strobe for a bad address: report straight away
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_STROBE;
          cs_d    = cs_q;
          unique case (op_q)
            OP_READ:  oe_d = 1'b1;
            OP_WRITE: begin
              we_d      = 1'b1;
              data_oe_d = 1'b1;
            end
            OP_INC:   cnt_en_d   = 1'b1;
            OP_CLR:   sync_clr_d = 1'b1;
          endcase
        end
      end
      S_STROBE: begin
        state_d = S_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        // The selected slave drives data while OE is high; capture at the closing edge
        if (op_q == OP_READ) begin
          rdata_d = data;
        end
      end
      S_DONE: begin
        // Turnaround cycle: bus released, strobes low
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      cs_q       <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      cnt_en_q   <= 1'b0;
      sync_clr_q <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      cnt_en_q   <= cnt_en_d;
      sync_clr_q <= sync_clr_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.CS       = cs_q;
  assign bus.WE       = we_q;
  assign bus.OE       = oe_q;
  assign bus.CNT_EN   = cnt_en_q;
  assign bus.SYNC_CLR = sync_clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;

  assign data = data_oe_q ? data_out_q : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_bus_master_ctrl.sv
//==============================================================================
// Module   : tb_bus_master_ctrl
// Purpose  : Scoreboard bench for bus_master_ctrl: a 4-slave instance with a
//            register/counter slave model, and a 3-slave instance for the
//            out-of-range address cases.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_master_ctrl;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] IN = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  typedef struct packed {
    int         id;
    logic       err;
    logic [7:0] rd;
    logic [3:0] cs;
    logic [3:0] strb;
    logic [7:0] wd;
    int         t;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   ncnt     = 0;

  exp_t qa[$];
  exp_t qb[$];

  wire [7:0] data_a;
  wire [7:0] data_b;

  bus_master_ctrl_if #(.DATA_WIDTH(8), .NUM_DEV(4), .ADDR_WIDTH(2)) bifa ();
  bus_master_ctrl_if #(.DATA_WIDTH(8), .NUM_DEV(3), .ADDR_WIDTH(2)) bifb ();

  bus_master_ctrl #(.DATA_WIDTH(8), .NUM_DEV(4), .ADDR_WIDTH(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bifa),
    .data  (data_a)
  );

  bus_master_ctrl #(.DATA_WIDTH(8), .NUM_DEV(3), .ADDR_WIDTH(2)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bifb),
    .data  (data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge counter used for latency expectations
  initial begin
    forever begin
      @(posedge clk);
      ncnt++;
    end
  end

  // Slave model for the 4-slave bus: registers with write, count and broadcast clear
  logic [7:0] sreg [4];
  logic [7:0] slv_val;
  logic       slv_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) sreg[i] <= 8'h00;
    end else if (bifa.SYNC_CLR) begin
      for (int i = 0; i < 4; i++) sreg[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bifa.CS[i] && bifa.WE)          sreg[i] <= data_a;
        else if (bifa.CS[i] && bifa.CNT_EN) sreg[i] <= sreg[i] + 8'd1;
      end
    end
  end

  always_comb begin
    slv_val = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (bifa.CS[i]) slv_val = sreg[i];
    end
    slv_en = bifa.OE && (bifa.CS != 4'b0000);
  end

  assign data_a = slv_en  ? slv_val : 8'hzz;
  assign data_b = bifb.OE ? 8'h5A   : 8'hzz;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cmd %0d): got 0x%0h, want 0x%0h", nm, id, act, exp);
    end
  endtask

  task automatic score(input exp_t e, input logic er, input logic [7:0] rd,
                       input logic [3:0] cs, input logic [3:0] strb, input int ns);
    chk("err",        e.id, 32'(er),   32'(e.err));
    chk("rdata",      e.id, 32'(rd),   32'(e.rd));
    chk("cs_seen",    e.id, 32'(cs),   32'(e.cs));
    chk("strobes",    e.id, 32'(strb), 32'(e.strb));
    chk("strobe_len", e.id, ns,        (e.strb != 4'b0000) ? 1 : 0);
    chk("latency",    e.id, ncnt,      e.t);
  endtask

  // Monitor for the 4-slave instance
  initial begin
    logic [3:0] acs;
    logic [3:0] astrb;
    logic [3:0] sa;
    int         ns;
    exp_t       e;
    acs = '0; astrb = '0; ns = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        acs = '0; astrb = '0; ns = 0;
      end else begin
        sa  = {bifa.WE, bifa.OE, bifa.CNT_EN, bifa.SYNC_CLR};
        acs = acs | bifa.CS;
        if (sa != 4'b0000) begin
          astrb = astrb | sa;
          ns++;
        end
        if (bifa.WE || bifa.OE)
          chk("we_oe_excl", -1, 32'(bifa.WE && bifa.OE), 32'd0);
        if (bifa.WE && qa.size() > 0)
          chk("wr_bus", qa[0].id, 32'(data_a), 32'(qa[0].wd));
        if (bifa.OE && qa.size() > 0)
          chk("rd_bus", qa[0].id, 32'(data_a), 32'(slv_val));
        if (bifa.done) begin
          if (qa.size() == 0) begin
            chk("spurious_done_a", -1, 32'd1, 32'd0);
          end else begin
            e = qa.pop_front();
            score(e, bifa.err, bifa.rdata, acs, astrb, ns);
          end
          acs = '0; astrb = '0; ns = 0;
        end
      end
    end
  end

  // Monitor for the 3-slave instance
  initial begin
    logic [3:0] bcs;
    logic [3:0] bstrb;
    logic [3:0] sb;
    int         ns;
    exp_t       e;
    bcs = '0; bstrb = '0; ns = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bcs = '0; bstrb = '0; ns = 0;
      end else begin
        sb  = {bifb.WE, bifb.OE, bifb.CNT_EN, bifb.SYNC_CLR};
        bcs = bcs | {1'b0, bifb.CS};
        if (sb != 4'b0000) begin
          bstrb = bstrb | sb;
          ns++;
        end
        if (bifb.done) begin
          if (qb.size() == 0) begin
            chk("spurious_done_b", -1, 32'd1, 32'd0);
          end else begin
            e = qb.pop_front();
            score(e, bifb.err, bifb.rdata, bcs, bstrb, ns);
          end
          bcs = '0; bstrb = '0; ns = 0;
        end
      end
    end
  end

  // Present one command at a negedge; the accepting edge follows immediately
  task automatic issue(input bit sel, input int id, input logic [1:0] o, input logic [1:0] a,
                       input logic [7:0] wd, input logic e_err, input logic [7:0] e_rd,
                       input logic [3:0] e_cs, input logic [3:0] e_strb, input bit hold);
    exp_t e;
    @(negedge clk);
    e.id = id; e.err = e_err; e.rd = e_rd; e.cs = e_cs; e.strb = e_strb; e.wd = wd;
    e.t  = ncnt + (e_err ? 2 : 3);
    if (!sel) begin
      bifa.req = 1'b1; bifa.op = o; bifa.addr = a; bifa.wdata = wd;
      qa.push_back(e);
    end else begin
      bifb.req = 1'b1; bifb.op = o; bifb.addr = a; bifb.wdata = wd;
      qb.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      bifa.req = 1'b0;
      bifb.req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bifa.req = 1'b0; bifa.op = RD; bifa.addr = 2'd0; bifa.wdata = 8'h00;
    bifb.req = 1'b0; bifb.op = RD; bifb.addr = 2'd0; bifb.wdata = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs",       0, 32'(bifa.CS),       32'd0);
    chk("rst_we",       0, 32'(bifa.WE),       32'd0);
    chk("rst_oe",       0, 32'(bifa.OE),       32'd0);
    chk("rst_cnt_en",   0, 32'(bifa.CNT_EN),   32'd0);
    chk("rst_sync_clr", 0, 32'(bifa.SYNC_CLR), 32'd0);
    chk("rst_busy",     0, 32'(bifa.busy),     32'd0);
    chk("rst_done",     0, 32'(bifa.done),     32'd0);
    chk("rst_err",      0, 32'(bifa.err),      32'd0);
    chk("rst_rdata",    0, 32'(bifa.rdata),    32'd0);
    chk("rst_busy_b",   0, 32'(bifb.busy),     32'd0);
    reset = 1'b1;

    // Reset for two cycles in the middle of a WRITE aborts it with no done
    @(negedge clk);
    bifa.req = 1'b1; bifa.op = WR; bifa.addr = 2'd0; bifa.wdata = 8'h55;
    @(negedge clk);
    bifa.req = 1'b0;
    chk("abort_setup_busy", 0, 32'(bifa.busy), 32'd1);
    chk("abort_setup_cs",   0, 32'(bifa.CS),   32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cs",   0, 32'(bifa.CS),   32'd0);
    chk("abort_we",   0, 32'(bifa.WE),   32'd0);
    chk("abort_busy", 0, 32'(bifa.busy), 32'd0);
    chk("abort_done", 0, 32'(bifa.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_slave0", 0, 32'(sreg[0]), 32'd0);

    // Write then read back
    issue(0, 1, WR, 2'd1, 8'hA5, 1'b0, 8'h00, 4'b0010, 4'b1000, 0);
    issue(0, 2, RD, 2'd1, 8'hC3, 1'b0, 8'hA5, 4'b0010, 4'b0100, 0);
    // Counter wrap
    issue(0, 3, WR, 2'd2, 8'hFF, 1'b0, 8'hA5, 4'b0100, 4'b1000, 0);
    issue(0, 4, IN, 2'd2, 8'hC3, 1'b0, 8'hA5, 4'b0100, 4'b0010, 0);
    issue(0, 5, RD, 2'd2, 8'hC3, 1'b0, 8'h00, 4'b0100, 4'b0100, 0);
    // Broadcast clear
    issue(0, 6,  WR, 2'd0, 8'h03, 1'b0, 8'h00, 4'b0001, 4'b1000, 0);
    issue(0, 7,  WR, 2'd3, 8'h07, 1'b0, 8'h00, 4'b1000, 4'b1000, 0);
    issue(0, 8,  RD, 2'd3, 8'hC3, 1'b0, 8'h07, 4'b1000, 4'b0100, 0);
    issue(0, 9,  CL, 2'd3, 8'hC3, 1'b0, 8'h07, 4'b0000, 4'b0001, 0);
    issue(0, 10, RD, 2'd0, 8'hC3, 1'b0, 8'h00, 4'b0001, 4'b0100, 0);
    issue(0, 11, RD, 2'd3, 8'hC3, 1'b0, 8'h00, 4'b1000, 4'b0100, 0);
    // req held high: one command every 4 cycles
    issue(0, 12, WR, 2'd1, 8'h3C, 1'b0, 8'h00, 4'b0010, 4'b1000, 1);
    issue(0, 13, RD, 2'd1, 8'hC3, 1'b0, 8'h3C, 4'b0010, 4'b0100, 1);
    issue(0, 14, IN, 2'd1, 8'hC3, 1'b0, 8'h3C, 4'b0010, 4'b0010, 1);
    issue(0, 15, RD, 2'd1, 8'hC3, 1'b0, 8'h3D, 4'b0010, 4'b0100, 1);
    issue(0, 16, WR, 2'd1, 8'h80, 1'b0, 8'h3D, 4'b0010, 4'b1000, 1);
    issue(0, 17, RD, 2'd1, 8'hC3, 1'b0, 8'h80, 4'b0010, 4'b0100, 1);
    @(negedge clk);
    bifa.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_hold", 17, 32'(bifa.busy), 32'd0);

    // Three-slave instance: out-of-range addresses
    issue(1, 20, RD, 2'd0, 8'hC3, 1'b0, 8'h5A, 4'b0001, 4'b0100, 0);
    issue(1, 21, RD, 2'd3, 8'hC3, 1'b1, 8'h5A, 4'b0000, 4'b0000, 0);
    issue(1, 22, WR, 2'd3, 8'h11, 1'b1, 8'h5A, 4'b0000, 4'b0000, 0);
    issue(1, 23, IN, 2'd3, 8'hC3, 1'b1, 8'h5A, 4'b0000, 4'b0000, 0);
    issue(1, 24, CL, 2'd3, 8'hC3, 1'b0, 8'h5A, 4'b0000, 4'b0001, 0);

    repeat (5) @(negedge clk);
    chk("queue_a_drained", -1, 32'(qa.size()), 32'd0);
    chk("queue_b_drained", -1, 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
